icache_line_fill_adapter: RTL and testbench

Parametrised line-fill adapter between the instruction cache's downward-facing port and the burst memory interface. It converts one line request into one memory burst, assembles `BEATS = LINE_BITS/BUS_BITS` in-order beats into a full line, and returns the line with a one-cycle response. Line width, bus width and address width are generics. An optional one-entry next-line prefetch buffer returns sequential fetches in one cycle.

---
 rtl/icache_line_fill_adapter.sv | 173 +++++++++++++++++
 tb/tb_icache_line_fill_adapter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill_adapter.sv
// Line-fill adapter: one cache line request becomes one in-order memory burst, returned as a full line.
// Optional one-entry next-line prefetch buffer, enabled by defining ICACHE_NEXT_LINE_PREFETCH_EN.
module icache_line_fill_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BUS_BITS  = 64,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] dfp_addr_i,
  input  logic                 dfp_read_i,
  output logic [LINE_BITS-1:0] dfp_rdata_o,
  output logic                 dfp_resp_o,
  output logic [ADDR_BITS-1:0] bmem_addr_o,
  output logic                 bmem_read_o,
  input  logic                 bmem_ready_i,
  input  logic                 bmem_rvalid_i,
  input  logic [BUS_BITS-1:0]  bmem_rdata_i,
  output logic                 pf_hit_o
);

  localparam int BEATS = LINE_BITS / BUS_BITS;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0]     LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_BITS-1:0] LINE_BYTES = ADDR_BITS'(LINE_BITS / 8);

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, FILL, RESP, PF_REQ, PF_FILL} state_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_e;
`endif

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [LINE_BITS-1:0]   line_d;
  logic [LINE_BITS-1:0]   dfp_rdata_q;
  logic                   dfp_resp_q;
  logic [ADDR_BITS-1:0]   bmem_addr_q;
  logic                   bmem_read_q;
  logic [ADDR_BITS-1:0]   req_line;
  logic                   unused_offset;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic                   pf_valid_q;
  logic [ADDR_BITS-1:0]   pf_tag_q;
  logic [LINE_BITS-1:0]   pf_line_q;
  logic                   pf_hit_q;
`endif

  assign req_line      = {dfp_addr_i[ADDR_BITS-1:OFF_W], OFF_W'(0)};
  assign unused_offset = ^dfp_addr_i[OFF_W-1:0];

  // Current line register with the incoming beat merged into its slot; shared by demand and prefetch fills.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        line_d[k*BUS_BITS +: BUS_BITS] = bmem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      dfp_rdata_q <= '0;
      dfp_resp_q  <= 1'b0;
      bmem_addr_q <= '0;
      bmem_read_q <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_valid_q  <= 1'b0;
      pf_tag_q    <= '0;
      pf_line_q   <= '0;
      pf_hit_q    <= 1'b0;
`endif
    end else begin
      dfp_resp_q <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_hit_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (dfp_read_i) begin
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            if (pf_valid_q && (req_line == pf_tag_q)) begin
              state_q     <= RESP;
              dfp_resp_q  <= 1'b1;
              pf_hit_q    <= 1'b1;
              dfp_rdata_q <= pf_line_q;
              pf_valid_q  <= 1'b0;
              bmem_addr_q <= req_line;
            end else begin
              pf_valid_q  <= 1'b0;
              state_q     <= REQ;
              bmem_read_q <= 1'b1;
              bmem_addr_q <= req_line;
            end
`else
            state_q     <= REQ;
            bmem_read_q <= 1'b1;
            bmem_addr_q <= req_line;
`endif
          end
        end
        REQ: begin
          if (bmem_ready_i) begin
            state_q     <= FILL;
            bmem_read_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        FILL: begin
          if (bmem_rvalid_i) begin
            line_q <= line_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q     <= RESP;
              dfp_resp_q  <= 1'b1;
              dfp_rdata_q <= line_d;
            end
          end
        end
        RESP: begin
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
          // bmem_addr_q still holds the line just returned; fetch its successor.
          state_q     <= PF_REQ;
          bmem_read_q <= 1'b1;
          bmem_addr_q <= bmem_addr_q + LINE_BYTES;
`else
          state_q <= IDLE;
`endif
        end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        PF_REQ: begin
          if (bmem_ready_i) begin
            state_q     <= PF_FILL;
            bmem_read_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        PF_FILL: begin
          if (bmem_rvalid_i) begin
            line_q <= line_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q    <= IDLE;
              pf_line_q  <= line_d;
              pf_valid_q <= 1'b1;
              pf_tag_q   <= bmem_addr_q;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dfp_rdata_o = dfp_rdata_q;
  assign dfp_resp_o  = dfp_resp_q;
  assign bmem_addr_o = bmem_addr_q;
  assign bmem_read_o = bmem_read_q;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  assign pf_hit_o    = pf_hit_q;
`else
  assign pf_hit_o    = 1'b0;
`endif

endmodule

// File: tb/tb_icache_line_fill_adapter.sv
// Directed bench for icache_line_fill_adapter (default parameters); expected lines go through a scoreboard queue.
// Prefetch scenarios run when ICACHE_NEXT_LINE_PREFETCH_EN is defined.
module tb_icache_line_fill_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready;
  logic         bmem_rvalid;
  logic [63:0]  bmem_rdata;
  logic         pf_hit;

  int total = 0;
  int bad   = 0;
  int rc;
  logic [255:0] expQ[$];

  icache_line_fill_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .dfp_addr_i   (dfp_addr),
    .dfp_read_i   (dfp_read),
    .dfp_rdata_o  (dfp_rdata),
    .dfp_resp_o   (dfp_resp),
    .bmem_addr_o  (bmem_addr),
    .bmem_read_o  (bmem_read),
    .bmem_ready_i (bmem_ready),
    .bmem_rvalid_i(bmem_rvalid),
    .bmem_rdata_i (bmem_rdata),
    .pf_hit_o     (pf_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] mkLine(input logic [63:0] b);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One demand fill: stall = cycles of bmem_ready low, gap = idle cycles after beat 1,
  // abortAfter = beat index at which rst is asserted instead (-1 for none). respCycle counts from cycle N.
  task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] base, input int stall,
                               input int gap, input int abortAfter, output int respCycle);
    logic [31:0] aligned;
    int c;
    int beat;
    int g;
    aligned = {addr[31:5], 5'b0};
    @(negedge clk);
    dfp_read    = 1'b1;
    dfp_addr    = addr;
    bmem_rvalid = 1'b0;
    bmem_ready  = (stall == 0);
    expQ.push_back(mkLine(base));
    c = 0;
    respCycle = -1;
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      c++;
      checkOutput("bmem_read_held", 256'(bmem_read), 256'(1));
      checkOutput("bmem_addr_stable", 256'(bmem_addr), 256'(aligned));
      if (i == 0) dfp_addr = addr ^ 32'h0000_F0E0;
      bmem_ready = (i == stall);
    end
    beat = 0;
    g = 0;
    while (beat < 4) begin
      @(negedge clk);
      c++;
      checkOutput("resp_early", 256'(dfp_resp), 256'(0));
      if (beat == abortAfter) begin
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b0;
        rst         = 1'b1;
        #1;
        checkOutput("rst_dfp_resp", 256'(dfp_resp), 256'(0));
        checkOutput("rst_dfp_rdata", dfp_rdata, 256'(0));
        checkOutput("rst_bmem_read", 256'(bmem_read), 256'(0));
        checkOutput("rst_bmem_addr", 256'(bmem_addr), 256'(0));
        checkOutput("rst_pf_hit", 256'(pf_hit), 256'(0));
        void'(expQ.pop_back());
        respCycle = -2;
        return;
      end
      if (beat == 2 && g < gap) begin
        bmem_rvalid = 1'b0;
        g++;
      end else begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = base + 64'(beat);
        beat++;
      end
    end
    @(negedge clk);
    c++;
    bmem_rvalid = 1'b0;
    for (int k = 0; k < 20 && !dfp_resp; k++) begin
      @(negedge clk);
      c++;
    end
    checkOutput("dfp_resp", 256'(dfp_resp), 256'(1));
    checkOutput("dfp_rdata", dfp_rdata, expQ.pop_front());
    checkOutput("pf_hit_demand", 256'(pf_hit), 256'(0));
    respCycle = c;
    dfp_read = 1'b0;
  endtask

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  // Serve the prefetch burst following a response; optionally raise a demand read during beat 1.
  task automatic serveBurst(input logic [31:0] expAddr, input logic [63:0] base,
                            input bit raise, input logic [31:0] raiseAddr);
    int k;
    bmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("no_back_to_back_resp", 256'(dfp_resp), 256'(0));
    k = 0;
    while (!bmem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("pf_req", 256'(bmem_read), 256'(1));
    checkOutput("pf_addr", 256'(bmem_addr), 256'(expAddr));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bmem_rvalid = 1'b1;
      bmem_rdata  = base + 64'(b);
      if (raise && b == 1) begin
        dfp_read = 1'b1;
        dfp_addr = raiseAddr;
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    dfp_addr = '0;
    dfp_read = 1'b0;
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_dfp_resp", 256'(dfp_resp), 256'(0));
    checkOutput("reset_dfp_rdata", dfp_rdata, 256'(0));
    checkOutput("reset_bmem_read", 256'(bmem_read), 256'(0));
    checkOutput("reset_bmem_addr", 256'(bmem_addr), 256'(0));
    checkOutput("reset_pf_hit", 256'(pf_hit), 256'(0));
    rst = 1'b0;

    $display("[TB] stray beats while idle");
    @(negedge clk);
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    checkOutput("idle_rvalid_no_read", 256'(bmem_read), 256'(0));
    checkOutput("idle_rvalid_no_resp", 256'(dfp_resp), 256'(0));

    $display("[TB] basic miss 0x1234");
    applyStimulus(32'h0000_1234, 64'h0123_4567_89AB_CDA0, 0, 0, -1, rc);
    checkOutput("latency_basic", 256'(rc), 256'(6));
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    serveBurst(32'h0000_1240, 64'h5000_0000_0000_0000, 1'b0, 32'h0);
`else
    @(negedge clk);
    checkOutput("no_back_to_back_resp", 256'(dfp_resp), 256'(0));
    checkOutput("no_prefetch_req", 256'(bmem_read), 256'(0));
    checkOutput("pf_hit_tied", 256'(pf_hit), 256'(0));
`endif

    $display("[TB] ready stall 3 and beat gap 2");
    applyStimulus(32'h0000_2468, 64'hCAFE_0000_1111_0000, 3, 2, -1, rc);
    checkOutput("latency_stalled", 256'(rc), 256'(11));
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    serveBurst(32'h0000_2480, 64'h5100_0000_0000_0000, 1'b0, 32'h0);
`endif

    $display("[TB] reset after beat 2");
    applyStimulus(32'h0000_3000, 64'hBAD0_BAD0_BAD0_0000, 0, 0, 3, rc);
    checkOutput("abort_expq_empty", 256'(expQ.size()), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0000_3000, 64'h7777_6666_5555_0040, 0, 0, -1, rc);
    checkOutput("latency_after_reset", 256'(rc), 256'(6));

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    serveBurst(32'h0000_3020, 64'h5200_0000_0000_0000, 1'b0, 32'h0);

    $display("[TB] prefetch hit 0x100 -> 0x120");
    applyStimulus(32'h0000_0100, 64'h1000_0000_0000_0000, 0, 0, -1, rc);
    serveBurst(32'h0000_0120, 64'h1200_0000_0000_0000, 1'b0, 32'h0);
    @(negedge clk);
    bmem_rvalid = 1'b0;
    @(negedge clk);
    dfp_read = 1'b1;
    dfp_addr = 32'h0000_0124;
    expQ.push_back(mkLine(64'h1200_0000_0000_0000));
    @(negedge clk);
    checkOutput("pf_hit_resp", 256'(dfp_resp), 256'(1));
    checkOutput("pf_hit_flag", 256'(pf_hit), 256'(1));
    checkOutput("pf_hit_rdata", dfp_rdata, expQ.pop_front());
    dfp_read = 1'b0;
    serveBurst(32'h0000_0140, 64'h1400_0000_0000_0000, 1'b0, 32'h0);

    $display("[TB] prefetch mismatch 0x100 then 0x400");
    applyStimulus(32'h0000_0100, 64'h2000_0000_0000_0000, 0, 0, -1, rc);
    serveBurst(32'h0000_0120, 64'h2200_0000_0000_0000, 1'b1, 32'h0000_0400);
    applyStimulus(32'h0000_0400, 64'h4000_0000_0000_0000, 0, 0, -1, rc);
    checkOutput("latency_mismatch", 256'(rc), 256'(6));
    serveBurst(32'h0000_0420, 64'h4200_0000_0000_0000, 1'b0, 32'h0);

    $display("[TB] prefetch address wrap");
    applyStimulus(32'hFFFF_FFE4, 64'hF000_0000_0000_0000, 0, 0, -1, rc);
    serveBurst(32'h0000_0000, 64'hF100_0000_0000_0000, 1'b0, 32'h0);
    @(negedge clk);
    bmem_rvalid = 1'b0;
`endif

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
